// File: rtl/seg_capture_pkg.sv
// Shared definitions for the seven-segment capture block: FSM states, hex glyphs,
// error counter ceiling and digit-select helpers.
package seg_cap_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD
   } cap_state_t;

   typedef struct packed {
      logic [7:0] seg;
      logic [7:0] digit;
   } smp_t;

   // Glyphs as driven on seg[6:0] (g..a), common with the display drivers
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h58;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

   function automatic logic is_onehot(input logic [7:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

   function automatic logic [2:0] onehot_idx(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/seg_capture_pat_decode.sv
// Combinational seven-segment glyph to hex nibble lookup; hit is low for any
// pattern outside the 16-glyph table.
module seg_pat_decode
   import seg_cap_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nib,
   output logic       hit
);

   always_comb begin
      nib = 4'h0;
      hit = 1'b1;
      case (seg)
         SEG_0:   nib = 4'h0;
         SEG_1:   nib = 4'h1;
         SEG_2:   nib = 4'h2;
         SEG_3:   nib = 4'h3;
         SEG_4:   nib = 4'h4;
         SEG_5:   nib = 4'h5;
         SEG_6:   nib = 4'h6;
         SEG_7:   nib = 4'h7;
         SEG_8:   nib = 4'h8;
         SEG_9:   nib = 4'h9;
         SEG_A:   nib = 4'hA;
         SEG_B:   nib = 4'hB;
         SEG_C:   nib = 4'hC;
         SEG_D:   nib = 4'hD;
         SEG_E:   nib = 4'hE;
         SEG_F:   nib = 4'hF;
         default: hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_capture.sv
// Seven-segment bus capture: settles, decodes and stores the hex value per digit.
// Define SEG_CAP_ERRCNT_EN to build the saturating err_cnt counter; otherwise it reads 0.
module seg_capture
   import seg_cap_pkg::*;
#(
   parameter int STABLE_CNT = 4
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic [7:0]  seg_in,
   input  logic [7:0]  digit_in,
   output logic [31:0] value,
   output logic [7:0]  dp,
   output logic        valid,
   output logic [2:0]  valid_idx,
   output logic        err,
   output logic [7:0]  err_cnt
);

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CNT - 1);

   cap_state_t state_reg;
   smp_t       smp_reg;
   smp_t       snap_reg;
   logic [7:0] cnt_reg;
   logic       valid_reg;
   logic       err_reg;
   logic [2:0] valid_idx_reg;

   logic [3:0] dec_nib;
   logic       dec_hit;
   logic       smp_onehot;
   logic       smp_same;
   logic       dec_fire;

   seg_pat_decode u_dec (
      .seg (snap_reg.seg[6:0]),
      .nib (dec_nib),
      .hit (dec_hit)
   );

   always_comb begin
      smp_onehot = is_onehot(smp_reg.digit);
      smp_same   = (smp_reg == snap_reg);
      dec_fire   = (state_reg == SETTLE) && smp_same && (cnt_reg == CNT_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_reg     <= IDLE;
         smp_reg       <= '0;
         snap_reg      <= '0;
         cnt_reg       <= 8'd0;
         valid_reg     <= 1'b0;
         err_reg       <= 1'b0;
         valid_idx_reg <= 3'd0;
      end else begin
         smp_reg   <= '{seg: seg_in, digit: digit_in};
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (smp_onehot) begin
                  state_reg <= SETTLE;
                  snap_reg  <= smp_reg;
                  cnt_reg   <= 8'd0;
               end
            end
            SETTLE: begin
               if (!smp_same) begin
                  // Any bit change restarts the stability window on the new pattern
                  if (smp_onehot) begin
                     snap_reg <= smp_reg;
                     cnt_reg  <= 8'd0;
                  end else begin
                     state_reg <= IDLE;
                  end
               end else if (cnt_reg == CNT_LAST) begin
                  state_reg <= HOLD;
                  if (dec_hit) begin
                     valid_reg     <= 1'b1;
                     valid_idx_reg <= onehot_idx(snap_reg.digit);
                  end else begin
                     err_reg <= 1'b1;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 8'd1;
               end
            end
            HOLD: begin
               if (!smp_same) begin
                  if (smp_onehot) begin
                     state_reg <= SETTLE;
                     snap_reg  <= smp_reg;
                     cnt_reg   <= 8'd0;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Per-digit storage; a digit only changes on a successful decode addressed to it
   logic [3:0] nib_reg [8];
   logic       dp_reg  [8];

   for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      always_ff @(posedge clk) begin
         if (!rstb) begin
            nib_reg[gi] <= 4'h0;
            dp_reg[gi]  <= 1'b0;
         end else if (dec_fire && dec_hit && snap_reg.digit[gi]) begin
            nib_reg[gi] <= dec_nib;
            dp_reg[gi]  <= snap_reg.seg[7];
         end
      end
      assign value[4*gi +: 4] = nib_reg[gi];
      assign dp[gi]           = dp_reg[gi];
   end

`ifdef SEG_CAP_ERRCNT_EN
   logic [7:0] err_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rstb) begin
         err_cnt_reg <= 8'd0;
      end else if (dec_fire && !dec_hit && (err_cnt_reg != ERR_CNT_MAX)) begin
         err_cnt_reg <= err_cnt_reg + 8'd1;
      end
   end

   assign err_cnt = err_cnt_reg;
`else
   assign err_cnt = 8'd0;
`endif

   assign valid     = valid_reg;
   assign err       = err_reg;
   assign valid_idx = valid_idx_reg;

endmodule

// File: tb/tb_seg_capture.sv
// Scoreboard bench for seg_capture: expected events are queued when a pattern is
// driven and checked (kind, cycle, index, stored state) when the DUT pulses.
module tb_seg_capture;

   localparam int STABLE = 4;
   localparam int LAT    = STABLE + 2;

`ifdef SEG_CAP_ERRCNT_EN
   localparam logic [7:0] SAT_EXP = 8'hFF;
`else
   localparam logic [7:0] SAT_EXP = 8'h00;
`endif

   logic        clk = 1'b0;
   logic        rstb;
   logic [7:0]  seg_in;
   logic [7:0]  digit_in;
   logic [31:0] value;
   logic [7:0]  dp;
   logic        valid;
   logic [2:0]  valid_idx;
   logic        err;
   logic [7:0]  err_cnt;

   seg_capture #(.STABLE_CNT(STABLE)) dut (
      .clk       (clk),
      .rstb      (rstb),
      .seg_in    (seg_in),
      .digit_in  (digit_in),
      .value     (value),
      .dp        (dp),
      .valid     (valid),
      .valid_idx (valid_idx),
      .err       (err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit         is_err;
      int         cyc;
      logic [2:0] idx;
      logic [31:0] value;
      logic [7:0] dp;
      logic [7:0] errc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [31:0] exp_value = '0;
   logic [7:0]  exp_dp    = '0;
   logic [7:0]  exp_errc  = '0;
   int          n_tests   = 0;
   int          n_fail    = 0;

   task automatic push_valid(input int t0, input logic [2:0] idx, input logic [3:0] nib,
                             input logic dpb);
      exp_value[idx*4 +: 4] = nib;
      exp_dp[idx]           = dpb;
      sb.push_back('{is_err: 1'b0, cyc: t0 + LAT, idx: idx, value: exp_value,
                     dp: exp_dp, errc: exp_errc});
   endtask

   task automatic push_err(input int t0);
`ifdef SEG_CAP_ERRCNT_EN
      if (exp_errc != 8'hFF) exp_errc = exp_errc + 8'd1;
`endif
      sb.push_back('{is_err: 1'b1, cyc: t0 + LAT, idx: 3'd0, value: exp_value,
                     dp: exp_dp, errc: exp_errc});
   endtask

   // Called from a negedge; returns the cycle number the new inputs were applied in.
   task automatic set_in(input logic [7:0] s, input logic [7:0] d, output int t0);
      seg_in   = s;
      digit_in = d;
      t0       = cyc;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d expected events never seen, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   always @(negedge clk) begin
      if (valid === 1'b1 || err === 1'b1) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: valid=%b err=%b idx=%0d cyc=%0d, required no event",
                     valid, err, valid_idx, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (valid !== !mon_e.is_err || err !== mon_e.is_err || cyc !== mon_e.cyc ||
                (!mon_e.is_err && valid_idx !== mon_e.idx) || value !== mon_e.value ||
                dp !== mon_e.dp || err_cnt !== mon_e.errc) begin
               n_fail++;
               $display("FAIL event: got v=%b e=%b cyc=%0d idx=%0d value=%h dp=%h errc=%0d, required v=%b e=%b cyc=%0d idx=%0d value=%h dp=%h errc=%0d",
                        valid, err, cyc, valid_idx, value, dp, err_cnt,
                        !mon_e.is_err, mon_e.is_err, mon_e.cyc, mon_e.idx, mon_e.value,
                        mon_e.dp, mon_e.errc);
            end else begin
               $display("[TB] cyc=%0d %s idx=%0d value=%h dp=%h err_cnt=%0d", cyc,
                        mon_e.is_err ? "err  " : "valid", valid_idx, value, dp, err_cnt);
            end
         end
      end
   end

   task automatic check_zero(input string name);
      n_tests++;
      if (value !== 32'h0 || dp !== 8'h0 || valid !== 1'b0 || valid_idx !== 3'd0 ||
          err !== 1'b0 || err_cnt !== 8'h0) begin
         n_fail++;
         $display("FAIL %s: value=%h dp=%h valid=%b idx=%0d err=%b errc=%0d, required all 0",
                  name, value, dp, valid, valid_idx, err, err_cnt);
      end
   endtask

   task automatic test_reset();
      int t0;
      rstb = 1'b0;
      set_in(8'h3F, 8'h01, t0);
      wait_cyc(4);
      check_zero("reset_state");
      rstb = 1'b1;
      t0   = cyc;
      push_valid(t0, 3'd0, 4'h0, 1'b0);
      wait_cyc(20);
      drain("reset_release");
   endtask

   task automatic test_dp_digit7();
      int t0;
      set_in(8'hF1, 8'h80, t0);
      push_valid(t0, 3'd7, 4'hF, 1'b1);
      wait_cyc(8);
      drain("dp_digit7");
      n_tests++;
      if (value[31:28] !== 4'hF || dp[7] !== 1'b1) begin
         n_fail++;
         $display("FAIL dp_digit7_state: value[31:28]=%h dp[7]=%b, required F 1",
                  value[31:28], dp[7]);
      end
   endtask

   task automatic test_restart();
      int t0;
      set_in(8'h5B, 8'h04, t0);
      wait_cyc(3);
      set_in(8'h4F, 8'h04, t0);
      push_valid(t0, 3'd2, 4'h3, 1'b0);
      wait_cyc(8);
      drain("restart");
      n_tests++;
      if (value[11:8] !== 4'h3) begin
         n_fail++;
         $display("FAIL restart_state: value[11:8]=%h, required 3", value[11:8]);
      end
   endtask

   task automatic test_back_to_back();
      int t0;
      set_in(8'h66, 8'h02, t0);
      push_valid(t0, 3'd1, 4'h4, 1'b0);
      wait_cyc(6);
      set_in(8'hF9, 8'h02, t0);
      push_valid(t0, 3'd1, 4'hE, 1'b1);
      wait_cyc(6);
      set_in(8'h5E, 8'h10, t0);
      push_valid(t0, 3'd4, 4'hD, 1'b0);
      wait_cyc(8);
      drain("back_to_back");
   endtask

   task automatic test_miss();
      int t0;
      set_in(8'h00, 8'h02, t0);
      push_err(t0);
      wait_cyc(6);
      set_in(8'h12, 8'h02, t0);
      push_err(t0);
      wait_cyc(8);
      drain("miss");
   endtask

   task automatic test_err_saturate();
      int t0;
      for (int i = 0; i < 300; i++) begin
         set_in((i % 2 == 0) ? 8'h00 : 8'h12, 8'h02, t0);
         push_err(t0);
         wait_cyc(6);
      end
      drain("err_saturate");
      n_tests++;
      if (err_cnt !== SAT_EXP) begin
         n_fail++;
         $display("FAIL err_saturate_cnt: err_cnt=%0d, required %0d", err_cnt, SAT_EXP);
      end
   endtask

   task automatic test_multihot();
      int t0;
      logic [31:0] v0;
      v0 = exp_value;
      set_in(8'h06, 8'h03, t0);
      wait_cyc(20);
      n_tests++;
      if (value !== v0 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL multihot: value=%h pending=%0d, required %h 0", value, sb.size(), v0);
      end
   endtask

   task automatic test_reset_mid();
      int t0;
      set_in(8'h3F, 8'h01, t0);
      wait_cyc(3);
      rstb      = 1'b0;
      exp_value = '0;
      exp_dp    = '0;
      exp_errc  = '0;
      wait_cyc(1);
      check_zero("reset_mid_a");
      wait_cyc(5);
      check_zero("reset_mid_b");
      set_in(8'h3F, 8'h00, t0);
      rstb = 1'b1;
      wait_cyc(10);
      check_zero("reset_mid_after");
      set_in(8'h7D, 8'h20, t0);
      push_valid(t0, 3'd5, 4'h6, 1'b0);
      wait_cyc(8);
      drain("reset_mid_resume");
   endtask

   initial begin
      rstb     = 1'b0;
      seg_in   = 8'h00;
      digit_in = 8'h00;
      @(negedge clk);
      test_reset();
      test_dp_digit7();
      test_restart();
      test_back_to_back();
      test_miss();
      test_err_saturate();
      test_multihot();
      test_reset_mid();
      wait_cyc(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_capture.md
# seg_capture

Seven-segment bus capture block: samples the multiplexed `seg`/`digit` lines driven by the board's display drivers and recovers the hex value shown on each digit. It sits beside the display drivers as a self-check and loopback monitor. It waits for each pattern to settle, decodes it against the standard 16-glyph hex table, stores the nibble and decimal point per digit, and flags unknown patterns.

## Interface
- `STABLE_CNT`, default 4: consecutive cycles a sampled `{seg,digit}` must hold before it is decoded; legal range 1..255.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rstb`  in  1  reset; synchronous, active-low.
- `seg_in`  in  8  segment lines, active-high; bit7 = dp, bits6..0 = g..a.
- `digit_in`  in  8  digit select, active-high; bit i = digit i.
- `value`  out  32  captured nibbles; digit i in `value[4i+3:4i]`; reset 0.
- `dp`  out  8  captured decimal point per digit; reset 0.
- `valid`  out  1  one-cycle pulse when a digit is written; reset 0.
- `valid_idx`  out  3  index of the digit written; meaningful only with `valid`; reset 0.
- `err`  out  1  one-cycle pulse when a settled pattern is not in the table; reset 0.
- `err_cnt`  out  8  saturating error count; reset 0.

## Operation
- Input register `smp` captures `{seg_in,digit_in}` every cycle. The FSM sees only `smp`.
- `snap` holds the pattern under test. `cnt` is the stability counter.
- Decode table (`seg[6:0]` to nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 58→C, 5E→D, 79→E, 71→F. Any other code is a miss. dp is not part of the lookup.
- FSM states:
  - IDLE
    - `smp.digit` is exactly one-hot → SETTLE; `snap`=`smp`, `cnt`=0.
    - Otherwise (zero or multi-hot) → stay in IDLE. No error is flagged.
  - SETTLE
    - `smp`≠`snap` and new digit one-hot → `snap`=`smp`, `cnt`=0, stay in SETTLE.
    - `smp`≠`snap` and new digit not one-hot → IDLE.
    - `smp`==`snap` and `cnt`==`STABLE_CNT`-1 → decode `snap`, go to HOLD.
      - Hit: write the nibble and dp bit for digit i, pulse `valid`, set `valid_idx`=i.
      - Miss: pulse `err`, increment `err_cnt`; `value` and `dp` are unchanged.
    - Otherwise `cnt`++.
  - HOLD
    - `smp`==`snap` → stay. Exactly one event per stable pattern.
    - `smp`≠`snap` → SETTLE if one-hot (`snap`=`smp`, `cnt`=0), else IDLE.
- The same digit rewritten with the same value still pulses `valid`.
- `valid` and `err` are mutually exclusive; both are registered.
- `err_cnt` saturates at 255 and never wraps.

## Timing
- Edge 1 is the first rising edge at which a new one-hot pattern is present on the inputs.
  - `smp` updates at edge 1.
  - SETTLE is entered at edge 2.
  - `valid`/`err`, `value`, `dp` and `err_cnt` update at edge `STABLE_CNT`+2 and are visible in the following cycle.
  - With the default, the pulse is high after edge 6 for exactly one cycle.
- A change of even one bit during SETTLE restarts the count from the new pattern.
- With `STABLE_CNT`=1, decode happens on the first SETTLE cycle.
- Reset mid-operation: at the rstb-low edge every register returns to its reset value and the FSM to IDLE. A pending decode is dropped with no pulse. Capture restarts from the first one-hot sample after `rstb` rises.

## Configuration
- `SEG_CAP_ERRCNT_EN`
  - Defined: `err_cnt` counter is implemented as described.
  - Undefined: counter logic is removed and `err_cnt` is tied to 0. The `err` pulse is unaffected.

## Structure
- Package `seg_cap_pkg` holds:
  - The FSM state enum (IDLE, SETTLE, HOLD).
  - The 16 glyph constants `SEG_0`..`SEG_F`, shared with the display drivers.
  - `ERR_CNT_MAX` = 8'hFF.
- One sub-module, `seg_pat_decode`: combinational; input `seg[6:0]`; outputs `nib[3:0]` and `hit`.
- The FSM, counters and registers live in `seg_capture`.

## Test plan
- Reset held, then released with `seg_in`=3F, `digit_in`=01 held → one `valid` at edge 6 after release sampling; `valid_idx`=0, `value`=0x00000000, `dp`=0. No further pulses while the inputs are held.
- Drive 0xF1 on digit 0x80, held for 6 cycles → `value[31:28]`=F, `dp[7]`=1, single `valid` with `valid_idx`=7.
- Drive 5B on digit 04 for 3 cycles, change to 4F for 6 cycles → no pulse for 5B; single `valid`; `value[11:8]`=3.
- Drive 0x00 on digit 02, then 0x12 on digit 02, each held 6 cycles → two `err` pulses, `err_cnt`=2, `value` unchanged. After 300 misses `err_cnt`=255; with the macro undefined it stays 0.
- Multi-hot `digit_in`=03 with `seg_in`=06 held → no `valid` and no `err`. Assert `rstb` low during SETTLE of a valid pattern → no pulse, all outputs 0.
